// File: rtl/pe_scheduler.sv
// pe_scheduler: sequences a single PE through the 16 elements of a 4x4 result
// tile. For each element it clears the PE accumulator, runs SUM_CYCLES
// accumulate cycles, and then offers the PE result on a valid/ready output
// port. Elements are visited in row-major order.
//
// Optional feature: define PE_SCHED_PERF_EN to build a saturating 16-bit
// counter of backpressure cycles (CAPTURE with out_ready low). When the macro
// is undefined, perf_stall is tied to zero.
//
// Handshake: out_valid is raised in CAPTURE and held, together with out_data,
// out_row and out_col, until a cycle where out_valid && out_ready. The element
// is accepted in that cycle. out_valid never drops without acceptance, except
// on abort or reset.
module pe_scheduler #(
  parameter int unsigned SUM_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [1:0]  pe_row,
  output logic [1:0]  pe_col,
  output logic        pe_reset,
  output logic        pe_enable,
  input  logic [7:0]  pe_res,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic [1:0]  out_row,
  output logic [1:0]  out_col,
  output logic [15:0] perf_stall,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_RUN     = 3'd2,
    S_CAPTURE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [3:0] RUN_LOAD = 4'(SUM_CYCLES);

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic       start_accept;

  // State, element index and RUN down-counter registers
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic and per-state outputs
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    pe_reset     = 1'b0;
    pe_enable    = 1'b0;
    out_valid    = 1'b0;
    out_data     = 8'd0;
    done         = 1'b0;
    start_accept = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          start_accept = 1'b1;
          idx_d        = 4'd0;
          state_d      = S_CLEAR;
        end
      end
      S_CLEAR: begin
        pe_reset = 1'b1;
        cnt_d    = RUN_LOAD;
        state_d  = S_RUN;
      end
      S_RUN: begin
        pe_enable = 1'b1;
        // cnt_q walks SUM_CYCLES..1, so RUN lasts exactly SUM_CYCLES cycles
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = S_CAPTURE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_CAPTURE: begin
        // The PE is idle here, so pe_res is stable and can pass straight through
        out_valid = 1'b1;
        out_data  = pe_res;
        if (out_ready) begin
          if (idx_q == 4'd15) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 4'd1;
            state_d = S_CLEAR;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Abort overrides every transition, including an accepted handshake
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      idx_d   = 4'd0;
      cnt_d   = 4'd0;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign pe_row    = idx_q[3:2];
  assign pe_col    = idx_q[1:0];
  assign out_row   = idx_q[3:2];
  assign out_col   = idx_q[1:0];
  assign dbg_state = state_q;

`ifdef PE_SCHED_PERF_EN
  logic [15:0] stall_q, stall_d;

  // Saturating backpressure counter, cleared when a new tile is accepted
  always_comb begin
    stall_d = stall_q;
    if (start_accept) begin
      stall_d = 16'd0;
    end else if ((state_q == S_CAPTURE) && !out_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  // Backpressure counter register
  always_ff @(posedge clock) begin
    if (!reset) begin
      stall_q <= 16'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign perf_stall = stall_q;
`else
  assign perf_stall = 16'd0;
`endif

endmodule

// File: tb/tb_pe_scheduler.sv
// tb_pe_scheduler: directed bench for pe_scheduler (SUM_CYCLES = 2) with a
// behavioural PE, an expected-result queue and a negedge monitor.
module tb_pe_scheduler;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        out_ready = 1'b1;
  logic        busy, done, pe_reset, pe_enable, out_valid;
  logic [1:0]  pe_row, pe_col, out_row, out_col;
  logic [7:0]  pe_res, out_data;
  logic [15:0] perf_stall;
  logic [2:0]  dbg_state;

  always #5 clock = ~clock;

  pe_scheduler #(.SUM_CYCLES(2)) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .busy(busy), .done(done), .pe_row(pe_row), .pe_col(pe_col),
    .pe_reset(pe_reset), .pe_enable(pe_enable), .pe_res(pe_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .perf_stall(perf_stall),
    .dbg_state(dbg_state)
  );

  // Behavioural PE: each enable cycle adds 3*(index+1) to the accumulator
  logic [7:0] acc_q = 8'd0;
  logic [7:0] step;
  assign step   = ({4'd0, pe_row, pe_col} + 8'd1) * 8'd3;
  assign pe_res = acc_q;
  always @(posedge clock) begin
    if (pe_reset) acc_q <= 8'd0;
    else if (pe_enable) acc_q <= acc_q + step;
  end

  // ---------------- scoreboard ----------------
  logic [11:0] exp_q[$];
  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- monitor ----------------
  int          cyc_n = 0, t0 = 0, done_cyc = 0, done_cnt = 0;
  int          en_cnt = 0, rst_cnt = 0, en_after_rst = 0, busy_cnt = 0;
  int          stall_cnt = 0, run_len = 0;
  logic        prev_rst = 1'b0, prev_busy = 1'b0, hold_act = 1'b0;
  logic [1:0]  lat_row = 2'd0, lat_col = 2'd0;
  logic [11:0] hold_val = 12'd0, got;
  logic        stall_en = 1'b0, force_low = 1'b0;

  always @(negedge clock) begin
    cyc_n++;
    if (force_low) out_ready = 1'b0;
    else if (stall_en && out_valid && out_row == 2'd1 && out_col == 2'd2 && stall_cnt < 5) begin
      out_ready = 1'b0;
      stall_cnt++;
    end else out_ready = 1'b1;

    if (reset) begin
      if (busy && !prev_busy) t0 = cyc_n;
      if (busy) busy_cnt++;
      if (pe_enable) begin
        en_cnt++;
        if (run_len == 0 && prev_rst) en_after_rst++;
        run_len++;
      end else if (run_len != 0) begin
        if (busy) check("enable_run_len", run_len, 2);
        run_len = 0;
      end
      if (pe_reset) begin
        lat_row = pe_row;
        lat_col = pe_col;
        rst_cnt++;
      end
      if (pe_enable || out_valid) check("pe_index_hold", {pe_row, pe_col}, {lat_row, lat_col});
      if (done) begin
        done_cnt++;
        done_cyc = cyc_n - t0 + 1;
        check("done_exclusive", {out_valid, pe_enable, pe_reset}, 0);
      end
      got = {out_row, out_col, out_data};
      if (!out_valid) hold_act = 1'b0;
      if (out_valid && !out_ready) begin
        if (!hold_act) begin
          hold_act = 1'b1;
          hold_val = got;
        end else check("stall_stable", got, hold_val);
      end
      if (out_valid && out_ready) begin
        if (hold_act) check("stall_stable", got, hold_val);
        hold_act = 1'b0;
        check("sb_nonempty", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) check("out_element", got, exp_q.pop_front());
      end
    end
    prev_rst  = pe_reset & reset;
    prev_busy = busy & reset;
  end

  // ---------------- driver tasks ----------------
  task automatic push_tile();
    for (int i = 0; i < 16; i++)
      exp_q.push_back({2'(i >> 2), 2'(i & 3), 8'((i + 1) * 6)});
  endtask

  task automatic pulse_start();
    @(negedge clock); start = 1'b1;
    @(negedge clock); start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int d0);
    for (int k = 0; k < budget && done_cnt == d0; k++) @(negedge clock);
    check("done_seen", done_cnt - d0, 1);
    @(negedge clock);
    @(negedge clock);
    check("done_single", done_cnt - d0, 1);
    check("idle_after_done", busy, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pe_enable"}, pe_enable, 0);
    check({tag, "_pe_reset"}, pe_reset, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_rowcol"}, {out_row, out_col}, 0);
    check({tag, "_pe_rowcol"}, {pe_row, pe_col}, 0);
    check({tag, "_perf_stall"}, perf_stall, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int e0, r0, a0, b0, d0, found;
    // reset state
    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    reset = 1'b1;
    @(negedge clock);
    check_reset_outputs("post_reset");

    // tile 1: free-running output, stray start while busy
    e0 = en_cnt; r0 = rst_cnt; a0 = en_after_rst; b0 = busy_cnt; d0 = done_cnt;
    push_tile();
    pulse_start();
    repeat (8) @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    wait_done(200, d0);
    check("t1_done_cycle", done_cyc, 65);
    check("t1_busy_cycles", busy_cnt - b0, 65);
    check("t1_enable_cycles", en_cnt - e0, 32);
    check("t1_clear_cycles", rst_cnt - r0, 16);
    check("t1_enable_after_clear", en_after_rst - a0, 16);
    check("t1_sb_drained", exp_q.size(), 0);

    // tile 2: 5 cycles of backpressure at element (1,2)
    stall_en = 1'b1;
    d0 = done_cnt;
    push_tile();
    pulse_start();
    wait_done(200, d0);
    stall_en = 1'b0;
    check("t2_done_cycle", done_cyc, 70);
    check("t2_stall_cycles", stall_cnt, 5);
`ifdef PE_SCHED_PERF_EN
    check("t2_perf_stall", perf_stall, 5);
`else
    check("t2_perf_stall", perf_stall, 0);
`endif
    check("t2_sb_drained", exp_q.size(), 0);

    // tile 3: abort at first RUN cycle of element (2,0)
    push_tile();
    pulse_start();
    found = 0;
    for (int k = 0; k < 200 && found == 0; k++) begin
      if (pe_enable && pe_row == 2'd2 && pe_col == 2'd0) found = 1;
      else @(negedge clock);
    end
    check("t3_reached_2_0", found, 1);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    check("t3_abort_busy", busy, 0);
    check("t3_abort_valid", out_valid, 0);
    check("t3_abort_enable", pe_enable, 0);
    check("t3_abort_state", dbg_state, 0);
    check("t3_elements_before_abort", 16 - exp_q.size(), 8);
    exp_q.delete();
    d0 = done_cnt;
    repeat (80) @(negedge clock);
    check("t3_no_done", done_cnt - d0, 0);

    // tile 4: restart after abort begins at (0,0)
    d0 = done_cnt;
    push_tile();
    pulse_start();
    wait_done(200, d0);
    check("t4_done_cycle", done_cyc, 65);
    check("t4_sb_drained", exp_q.size(), 0);

    // reset while stalled in CAPTURE
    force_low = 1'b1;
    pulse_start();
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      if (out_valid) found = 1;
      else @(negedge clock);
    end
    check("t5_reached_capture", found, 1);
    reset = 1'b0;
    @(negedge clock);
    check_reset_outputs("mid_reset");
    reset = 1'b1;
    force_low = 1'b0;
    @(negedge clock);
    check_reset_outputs("after_mid_reset");

    check("final_sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pe_scheduler.md
PE_SCHEDULER -- requirements
Module: pe_scheduler

Interface
REQ-001 SHALL have parameter SUM_CYCLES, default 2, meaning the number of consecutive pe_enable cycles per output element (legal range 1..15).
REQ-002 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request to compute one full 4x4 result tile.
REQ-005 SHALL have port abort  input  1  cancel an in-progress tile.
REQ-006 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-007 SHALL have port done  output  1  one-cycle pulse when the tile completes.
REQ-008 SHALL have port pe_row, pe_col  output  2 each  element index driven to the PE select inputs.
REQ-009 SHALL have port pe_reset  output  1  active-high clear of the PE accumulator.
REQ-010 SHALL have port pe_enable  output  1  PE accumulate enable.
REQ-011 SHALL have port pe_res  input  8  PE registered result.
REQ-012 SHALL have port out_valid, out_ready  output/input  1 each  result valid/ready handshake.
REQ-013 SHALL have port out_data  output  8  captured element value.
REQ-014 SHALL have port out_row, out_col  output  2 each  index of out_data.
REQ-015 SHALL have port perf_stall  output  16  backpressure cycle count (see Configuration).

Function
REQ-016 SHALL implement states IDLE, CLEAR, RUN, CAPTURE, DONE.
REQ-017 IDLE: start=1 SHALL move to CLEAR with index 0 (row 0, col 0); start outside IDLE SHALL be ignored.
REQ-018 CLEAR SHALL last exactly 1 cycle with pe_reset=1, pe_enable=0, then go to RUN.
REQ-019 RUN SHALL hold pe_enable=1 for exactly SUM_CYCLES cycles via a down-counter, then go to CAPTURE.
REQ-020 CAPTURE SHALL drive out_valid=1, out_data=pe_res, out_row/out_col=current index, pe_enable=0; pe_res is sampled combinationally and stays stable because the PE is idle.
REQ-021 CAPTURE SHALL remain while out_ready=0 and SHALL keep all outputs stable.
REQ-022 On out_valid&&out_ready: if index=15 then go to DONE, else increment index and go to CLEAR.
REQ-023 Index order SHALL be row-major: col increments first, row increments when col wraps from 3 to 0.
REQ-024 pe_row/pe_col SHALL equal the current index and SHALL stay constant from CLEAR through CAPTURE of each element.
REQ-025 DONE SHALL assert done=1 for one cycle, then go to IDLE.
REQ-026 Latency with out_ready held 1: done SHALL be high in cycle 16*(SUM_CYCLES+2)+1 after the edge that samples start.
REQ-027 abort=1 in any non-IDLE state SHALL force IDLE at the next edge with no done pulse, including when abort and out_ready coincide in CAPTURE (abort wins).
REQ-028 abort in IDLE SHALL have no effect; start and abort together in IDLE SHALL move to CLEAR.
REQ-029 pe_reset, pe_enable, out_valid and done SHALL be 0 in every state other than the one that defines them.

Reset
REQ-030 reset=0 at a rising edge SHALL force IDLE, index 0, RUN counter 0 and perf_stall 0, regardless of state, including mid-tile.
REQ-031 While in reset and right after it: busy=0, done=0, pe_enable=0, pe_reset=0, out_valid=0, out_data=0, out_row=0, out_col=0, pe_row=0, pe_col=0.

Configuration
REQ-032 Macro PE_SCHED_PERF_EN defined: perf_stall SHALL count cycles in CAPTURE with out_ready=0, saturate at 16'hFFFF, and clear only on reset or an accepted start.
REQ-033 Macro PE_SCHED_PERF_EN undefined: perf_stall SHALL be constant 0 and no counter logic SHALL be present.

Verification
REQ-034 SUM_CYCLES=2, out_ready=1, pulse start -> 16 handshakes in order (0,0),(0,1)..(3,3), each out_data=pe_res, done high at cycle 65, busy cycles 1..65.
REQ-035 Check pe_enable pattern -> exactly 2 high cycles per element, each preceded by 1 pe_reset cycle; 32 enable cycles per tile.
REQ-036 Hold out_ready=0 for 5 cycles at element (1,2) -> outputs stable, state held; with PERF_EN, perf_stall=5 at done.
REQ-037 abort at the RUN cycle of element (2,0) -> IDLE next cycle, busy=0, no done; a new start restarts at (0,0).
REQ-038 reset=0 during CAPTURE with out_ready=0 -> all outputs at their reset values next cycle; start pulse while busy -> no effect on sequence or done timing.
